// File: rtl/pcileech_ft601_resp_pkg.sv
// Shared types and constants for the FT601 chip-side responder.
package pcileech_ft601_resp_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_TURN = 2'd1,
    RD_DATA = 2'd2,
    WR      = 2'd3
  } ft601_resp_state_t;

  localparam logic [31:0] FT601_RESP_UNDERRUN_WORD = 32'hFFFFFFFF;
  localparam logic [3:0]  FT601_RESP_BE_FULL       = 4'hF;

  typedef struct packed {
    logic [3:0]  be;
    logic [31:0] data;
  } ft601_cap_word_t;

endpackage

// File: rtl/pcileech_ft601_resp_fifo.sv
// First-word fall-through FIFO; pointers carry one extra wrap bit.
module pcileech_ft601_resp_fifo #(
  parameter int WIDTH      = 32,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push_i,
  input  logic [WIDTH-1:0]      wdata_i,
  input  logic                  pop_i,
  output logic [WIDTH-1:0]      rdata_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [DEPTH_LOG2:0]   count_o
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] PTR_ONE = 1;

  logic [WIDTH-1:0]    mem_q [DEPTH];
  logic [DEPTH_LOG2:0] wr_ptr_q, rd_ptr_q;
  logic                push_ok, pop_ok;

  assign full_o  = (wr_ptr_q[DEPTH_LOG2] != rd_ptr_q[DEPTH_LOG2]) &&
                   (wr_ptr_q[DEPTH_LOG2-1:0] == rd_ptr_q[DEPTH_LOG2-1:0]);
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign count_o = wr_ptr_q - rd_ptr_q;
  assign rdata_o = mem_q[rd_ptr_q[DEPTH_LOG2-1:0]];

  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
    end
  end

  // Storage carries no reset; only the pointers define occupancy.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q[DEPTH_LOG2-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/pcileech_ft601_responder.sv
// FT601 245-sync FIFO chip model: serves master reads from an inject FIFO, captures writes.
// Build option FT601_RESP_LOOPBACK_EN routes captured words straight back into the inject FIFO.
module pcileech_ft601_responder
  import pcileech_ft601_resp_pkg::*;
#(
  parameter int INJ_DEPTH_LOG2 = 4,
  parameter int CAP_DEPTH_LOG2 = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] inj_data_i,
  input  logic        inj_valid_i,
  output logic        inj_ready_o,
  output logic [31:0] cap_data_o,
  output logic [3:0]  cap_be_o,
  output logic        cap_valid_o,
  input  logic        cap_ready_i,
  input  logic [31:0] ft601_data_i,
  input  logic [3:0]  ft601_be_i,
  output logic [31:0] ft601_data_o,
  output logic [3:0]  ft601_be_o,
  output logic        ft601_data_oe_o,
  output logic        ft601_rxf_n_o,
  output logic        ft601_txe_n_o,
  input  logic        ft601_oe_n_i,
  input  logic        ft601_rd_n_i,
  input  logic        ft601_wr_n_i,
  input  logic        ft601_siwu_n_i,
  output logic        err_underrun_o,
  output logic        err_overflow_o,
  output logic        err_conflict_o
);
  localparam logic [CAP_DEPTH_LOG2:0] CAP_DEPTH_W = (1 << CAP_DEPTH_LOG2);
  localparam logic [CAP_DEPTH_LOG2:0] TXE_SLACK   = 2;

  ft601_resp_state_t state_q, state_d;
  logic data_oe_q, rxf_n_q, txe_n_q, rdy_q;
  logic underrun_q, overflow_q, conflict_q;

  logic conflict, rd_req, wr_req;
  logic inj_push, inj_pop, inj_full, inj_empty;
  logic [31:0] inj_wdata, inj_rdata;
  logic [INJ_DEPTH_LOG2:0] inj_count;
  logic cap_push, cap_pop, cap_full, cap_empty;
  ft601_cap_word_t cap_wdata, cap_rdata;
  logic [CAP_DEPTH_LOG2:0] cap_count, cap_free;
  logic unused_ok;

  assign unused_ok = &{1'b0, ft601_siwu_n_i, cap_ready_i};

  // A write strobe overlapping a read strobe is a master bug: freeze everything.
  assign conflict = !ft601_wr_n_i && (!ft601_oe_n_i || !ft601_rd_n_i);

  always_comb begin
    state_d = state_q;
    rd_req  = 1'b0;
    wr_req  = 1'b0;
    if (!conflict) begin
      case (state_q)
        IDLE: begin
          if (!ft601_oe_n_i) state_d = RD_TURN;
          else if (!ft601_wr_n_i) begin
            state_d = WR;
            wr_req  = 1'b1;
          end
        end
        RD_TURN: begin
          if (ft601_oe_n_i) state_d = IDLE;
          else if (!ft601_rd_n_i) begin
            state_d = RD_DATA;
            rd_req  = 1'b1;
          end
        end
        RD_DATA: begin
          if (ft601_oe_n_i)     state_d = IDLE;
          else if (ft601_rd_n_i) state_d = RD_TURN;
          else                   rd_req  = 1'b1;
        end
        WR: begin
          if (ft601_wr_n_i) state_d = IDLE;
          else              wr_req  = 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign inj_pop   = rd_req && !inj_empty;
  assign cap_push  = wr_req && !cap_full;
  assign cap_wdata = '{be: ft601_be_i, data: ft601_data_i};
  assign cap_free  = CAP_DEPTH_W - cap_count;

`ifdef FT601_RESP_LOOPBACK_EN
  logic lb_push;
  assign lb_push     = !cap_empty && !inj_full;
  assign inj_ready_o = rdy_q && !inj_full && cap_empty;
  assign inj_push    = lb_push || (inj_valid_i && inj_ready_o);
  assign inj_wdata   = lb_push ? cap_rdata.data : inj_data_i;
  assign cap_pop     = lb_push;
  assign cap_valid_o = 1'b0;
`else
  assign inj_ready_o = rdy_q && !inj_full;
  assign inj_push    = inj_valid_i && inj_ready_o;
  assign inj_wdata   = inj_data_i;
  assign cap_pop     = cap_valid_o && cap_ready_i;
  assign cap_valid_o = !cap_empty;
`endif

  assign cap_data_o = cap_rdata.data;
  assign cap_be_o   = cap_rdata.be;

  assign ft601_data_oe_o = data_oe_q;
  assign ft601_data_o    = !data_oe_q ? 32'h0 :
                           (inj_empty ? FT601_RESP_UNDERRUN_WORD : inj_rdata);
  assign ft601_be_o      = data_oe_q ? FT601_RESP_BE_FULL : 4'h0;
  assign ft601_rxf_n_o   = rxf_n_q;
  assign ft601_txe_n_o   = txe_n_q;
  assign err_underrun_o  = underrun_q;
  assign err_overflow_o  = overflow_q;
  assign err_conflict_o  = conflict_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      data_oe_q  <= 1'b0;
      rxf_n_q    <= 1'b1;
      txe_n_q    <= 1'b1;
      rdy_q      <= 1'b0;
      underrun_q <= 1'b0;
      overflow_q <= 1'b0;
      conflict_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      data_oe_q  <= (state_d == RD_TURN) || (state_d == RD_DATA);
      rxf_n_q    <= (inj_count == '0);
      txe_n_q    <= (cap_free < TXE_SLACK);
      rdy_q      <= 1'b1;
      underrun_q <= underrun_q || (rd_req && inj_empty);
      overflow_q <= overflow_q || (wr_req && cap_full);
      conflict_q <= conflict_q || conflict;
    end
  end

  pcileech_ft601_resp_fifo #(.WIDTH(32), .DEPTH_LOG2(INJ_DEPTH_LOG2)) u_inj_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (inj_push),
    .wdata_i (inj_wdata),
    .pop_i   (inj_pop),
    .rdata_o (inj_rdata),
    .full_o  (inj_full),
    .empty_o (inj_empty),
    .count_o (inj_count)
  );

  pcileech_ft601_resp_fifo #(.WIDTH($bits(ft601_cap_word_t)), .DEPTH_LOG2(CAP_DEPTH_LOG2)) u_cap_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (cap_push),
    .wdata_i (cap_wdata),
    .pop_i   (cap_pop),
    .rdata_o (cap_rdata),
    .full_o  (cap_full),
    .empty_o (cap_empty),
    .count_o (cap_count)
  );

endmodule

// File: tb/tb_pcileech_ft601_responder.sv
// Directed bench for the FT601 responder: vector table plus hand-written corner sequences.
module tb_pcileech_ft601_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] inj_data;
  logic        inj_valid, inj_ready;
  logic [31:0] cap_data;
  logic [3:0]  cap_be;
  logic        cap_valid, cap_ready;
  logic [31:0] din, dout;
  logic [3:0]  bein, beout;
  logic        data_oe, rxf_n, txe_n;
  logic        oe_n, rd_n, wr_n, siwu_n;
  logic        e_und, e_ovf, e_cfl;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  pcileech_ft601_responder #(.INJ_DEPTH_LOG2(4), .CAP_DEPTH_LOG2(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .inj_data_i(inj_data), .inj_valid_i(inj_valid), .inj_ready_o(inj_ready),
    .cap_data_o(cap_data), .cap_be_o(cap_be), .cap_valid_o(cap_valid), .cap_ready_i(cap_ready),
    .ft601_data_i(din), .ft601_be_i(bein),
    .ft601_data_o(dout), .ft601_be_o(beout), .ft601_data_oe_o(data_oe),
    .ft601_rxf_n_o(rxf_n), .ft601_txe_n_o(txe_n),
    .ft601_oe_n_i(oe_n), .ft601_rd_n_i(rd_n), .ft601_wr_n_i(wr_n), .ft601_siwu_n_i(siwu_n),
    .err_underrun_o(e_und), .err_overflow_o(e_ovf), .err_conflict_o(e_cfl)
  );

  typedef struct packed {
    logic        iv;
    logic [31:0] id;
    logic        oe_n, rd_n, wr_n;
    logic [31:0] din;
    logic [3:0]  be;
    logic        e_oe;
    logic [31:0] e_dout;
    logic        e_rxf;
    logic        e_capv;
  } vec_t;

  vec_t tbl [11];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle_bus();
    oe_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1;
    inj_valid = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; siwu_n = 1'b1; cap_ready = 1'b0;
    inj_data = '0; din = '0; bein = '0;
    idle_bus();
    step(); step();

    chk("rst rxf_n", rxf_n, 1'b1);
    chk("rst txe_n", txe_n, 1'b1);
    chk("rst data_oe", data_oe, 1'b0);
    chk("rst data_out", dout, 32'h0);
    chk("rst be_out", beout, 4'h0);
    chk("rst inj_ready", inj_ready, 1'b0);
    chk("rst cap_valid", cap_valid, 1'b0);
    chk("rst errs", {e_und, e_ovf, e_cfl}, 3'b000);

    rst_n = 1'b1;
    #1;
    chk("inj_ready before clk", inj_ready, 1'b0);
    step();
    chk("inj_ready after clk", inj_ready, 1'b1);
    chk("txe_n after clk", txe_n, 1'b0);
    step();

`ifdef FT601_RESP_LOOPBACK_EN
    wr_n = 1'b0; din = 32'hCAFEBABE; bein = 4'hF;
    step();
    wr_n = 1'b1;
    step(); step();
    chk("lb rxf_n", rxf_n, 1'b0);
    chk("lb cap_valid", cap_valid, 1'b0);
    oe_n = 1'b0;
    step();
    chk("lb data_out", dout, 32'hCAFEBABE);
    chk("lb data_oe", data_oe, 1'b1);
    rd_n = 1'b0;
    step();
    idle_bus();
    step();
    chk("lb cap_valid end", cap_valid, 1'b0);
    chk("lb rxf_n end", rxf_n, 1'b1);
    chk("lb errs", {e_und, e_ovf, e_cfl}, 3'b000);
`else
    //          iv    id            oe    rd    wr    din           be     e_oe  e_dout        rxf   capv
    tbl[0]  = '{1'b1, 32'h11111111, 1'b1, 1'b1, 1'b1, 32'h0,        4'h0,  1'b0, 32'h0,        1'b1, 1'b0};
    tbl[1]  = '{1'b1, 32'h22222222, 1'b1, 1'b1, 1'b1, 32'h0,        4'h0,  1'b0, 32'h0,        1'b0, 1'b0};
    tbl[2]  = '{1'b1, 32'h33333333, 1'b1, 1'b1, 1'b1, 32'h0,        4'h0,  1'b0, 32'h0,        1'b0, 1'b0};
    tbl[3]  = '{1'b0, 32'h0,        1'b0, 1'b1, 1'b1, 32'h0,        4'h0,  1'b1, 32'h11111111, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 32'h0,        4'h0,  1'b1, 32'h22222222, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 32'h0,        4'h0,  1'b1, 32'h33333333, 1'b0, 1'b0};
    tbl[6]  = '{1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 32'h0,        4'h0,  1'b1, 32'hFFFFFFFF, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 32'h0,        4'h0,  1'b0, 32'h0,        1'b1, 1'b0};
    tbl[8]  = '{1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 32'hA5A5A5A5, 4'h3,  1'b0, 32'h0,        1'b1, 1'b1};
    tbl[9]  = '{1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 32'h5A5A5A5A, 4'hC,  1'b0, 32'h0,        1'b1, 1'b1};
    tbl[10] = '{1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 32'h0,        4'h0,  1'b0, 32'h0,        1'b1, 1'b1};

    for (int k = 0; k < 11; k++) begin
      inj_valid = tbl[k].iv; inj_data = tbl[k].id;
      oe_n = tbl[k].oe_n; rd_n = tbl[k].rd_n; wr_n = tbl[k].wr_n;
      din = tbl[k].din; bein = tbl[k].be;
      step();
      chk($sformatf("vec%0d data_oe", k), data_oe, tbl[k].e_oe);
      chk($sformatf("vec%0d data_out", k), dout, tbl[k].e_dout);
      chk($sformatf("vec%0d be_out", k), beout, tbl[k].e_oe ? 4'hF : 4'h0);
      chk($sformatf("vec%0d rxf_n", k), rxf_n, tbl[k].e_rxf);
      chk($sformatf("vec%0d cap_valid", k), cap_valid, tbl[k].e_capv);
    end
    idle_bus();
    chk("no errs after table", {e_und, e_ovf, e_cfl}, 3'b000);

    chk("cap head0", {cap_be, cap_data}, {4'h3, 32'hA5A5A5A5});
    cap_ready = 1'b1;
    step();
    chk("cap head1", {cap_be, cap_data}, {4'hC, 32'h5A5A5A5A});
    step();
    chk("cap drained", cap_valid, 1'b0);
    cap_ready = 1'b0;

    // Underrun: read strobe against an empty inject FIFO.
    oe_n = 1'b0;
    step();
    rd_n = 1'b0;
    step();
    chk("underrun flag", e_und, 1'b1);
    chk("underrun data", dout, 32'hFFFFFFFF);
    idle_bus();
    step();
    chk("underrun oe drop", data_oe, 1'b0);

    // Overflow: 17 writes into a 16-deep capture FIFO with no consumer.
    for (int i = 0; i < 17; i++) begin
      wr_n = 1'b0; din = 32'hD0000000 + i; bein = i[3:0];
      step();
      if (i == 14) chk("txe_n after 15 pushes", txe_n, 1'b0);
      if (i == 15) begin
        chk("txe_n after 16 pushes", txe_n, 1'b1);
        chk("no overflow at 16", e_ovf, 1'b0);
      end
      if (i == 16) chk("overflow on 17th", e_ovf, 1'b1);
    end
    idle_bus();
    step();
    cap_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("ovf word%0d valid", i), cap_valid, 1'b1);
      chk($sformatf("ovf word%0d", i), {cap_be, cap_data}, {i[3:0], 32'hD0000000 + i});
      step();
    end
    chk("ovf drained", cap_valid, 1'b0);
    cap_ready = 1'b0;

    // Conflict: wr_n and oe_n together must not move either FIFO.
    inj_valid = 1'b1; inj_data = 32'h77777777;
    step();
    inj_valid = 1'b0;
    step(); step();
    wr_n = 1'b0; oe_n = 1'b0; din = 32'hBAD0BAD0; bein = 4'hF;
    step();
    chk("conflict flag", e_cfl, 1'b1);
    chk("conflict no oe", data_oe, 1'b0);
    chk("conflict no push", cap_valid, 1'b0);
    idle_bus();
    step(); step();
    chk("conflict inj kept", rxf_n, 1'b0);
    chk("conflict cap empty", cap_valid, 1'b0);
    oe_n = 1'b0;
    step();
    chk("conflict word intact", dout, 32'h77777777);
    rd_n = 1'b0;
    step();
    idle_bus();
    step(); step();
    chk("conflict inj drained", rxf_n, 1'b1);

    // Reset asserted in the middle of a 4-word read burst.
    for (int i = 0; i < 4; i++) begin
      inj_valid = 1'b1; inj_data = 32'h40 + i;
      step();
    end
    inj_valid = 1'b0;
    step(); step();
    oe_n = 1'b0;
    step();
    rd_n = 1'b0;
    step(); step();
    chk("burst mid data", dout, 32'h42);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst data_oe", data_oe, 1'b0);
    chk("midrst rxf_n", rxf_n, 1'b1);
    chk("midrst inj_ready", inj_ready, 1'b0);
    chk("midrst errs", {e_und, e_ovf, e_cfl}, 3'b000);
    idle_bus();
    step();
    rst_n = 1'b1;
    step(); step(); step();
    chk("postrst rxf_n", rxf_n, 1'b1);
    chk("postrst inj_ready", inj_ready, 1'b1);
    chk("postrst cap_valid", cap_valid, 1'b0);
    oe_n = 1'b0;
    step();
    chk("postrst inj empty", dout, 32'hFFFFFFFF);
    idle_bus();
    step();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
